// File: rtl/mips150_mem_arbiter.sv
// Shares the single MIPS150 memory port between instruction fetch and load/store.
// Store encodings become byte-lane masks; each access is a request/ready handshake with timeout.
module mips150_mem_arbiter #(
    parameter int WAIT_LIMIT   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic        err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall
);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_LIMIT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_reg, state_next;
    logic        gnt_d_reg;
    logic        misalign_reg;
    logic        err_reg;
    logic [7:0]  wait_cnt_reg;
    logic [3:0]  starve_cnt_reg;
    logic [31:0] addr_reg;
    logic [3:0]  we_reg;
    logic [31:0] wdata_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] d_rdata_reg;

    logic        fetch_starved;
    logic        grant_d;
    logic        grant_any;
    logic        d_misaligned;
    logic [3:0]  d_mask;
    logic [31:0] d_lanes;
    logic        timeout;
    logic        if_addr_lsb_unused;

    assign if_addr_lsb_unused = ^if_addr[1:0];

    // Store decode: lane mask, replicated data and alignment check
    always_comb begin
        d_mask       = 4'b0000;
        d_lanes      = 32'h0;
        d_misaligned = 1'b0;
        case (d_we)
            2'b01: begin
                d_mask  = 4'b0001 << d_addr[1:0];
                d_lanes = {4{d_wdata[7:0]}};
            end
            2'b10: begin
                d_mask       = 4'b0011 << {d_addr[1], 1'b0};
                d_lanes      = {2{d_wdata[15:0]}};
                d_misaligned = d_addr[0];
            end
            2'b11: begin
                d_mask       = 4'b1111;
                d_lanes      = d_wdata;
                d_misaligned = |d_addr[1:0];
            end
            default: ;
        endcase
    end

    // Data normally wins; fetch takes over once it has lost STARVE_LIMIT grants in a row
    assign fetch_starved = if_req && (starve_cnt_reg == STARVE_MAX);
    assign grant_d       = d_req && !fetch_starved;
    assign grant_any     = d_req || if_req;
    assign timeout       = (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = (grant_d && d_misaligned) ? RESP : BUSY;
            BUSY:    if (mem_ready || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_valid  = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        d_misalign = 1'b0;
        err        = 1'b0;
        case (state_reg)
            BUSY: mem_valid = 1'b1;
            RESP: begin
                if_ack     = ~gnt_d_reg;
                d_ack      = gnt_d_reg;
                d_misalign = misalign_reg;
                err        = err_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_d_reg      <= 1'b0;
            misalign_reg   <= 1'b0;
            err_reg        <= 1'b0;
            wait_cnt_reg   <= 8'd0;
            starve_cnt_reg <= 4'd0;
            addr_reg       <= 32'h0;
            we_reg         <= 4'b0000;
            wdata_reg      <= 32'h0;
            if_rdata_reg   <= 32'h0;
            d_rdata_reg    <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: if (grant_any) begin
                    gnt_d_reg    <= grant_d;
                    misalign_reg <= grant_d && d_misaligned;
                    err_reg      <= 1'b0;
                    wait_cnt_reg <= 8'd0;
                    if (grant_d) begin
                        if (if_req && starve_cnt_reg != STARVE_MAX)
                            starve_cnt_reg <= starve_cnt_reg + 4'd1;
                        if (d_misaligned) begin
                            d_rdata_reg <= 32'h0;
                        end else begin
                            addr_reg  <= {d_addr[31:2], 2'b00};
                            we_reg    <= d_mask;
                            wdata_reg <= d_lanes;
                        end
                    end else begin
                        starve_cnt_reg <= 4'd0;
                        addr_reg       <= {if_addr[31:2], 2'b00};
                        we_reg         <= 4'b0000;
                        wdata_reg      <= 32'h0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (gnt_d_reg) d_rdata_reg <= (we_reg == 4'b0000) ? mem_rdata : 32'h0;
                        else           if_rdata_reg <= mem_rdata;
                    end else if (timeout) begin
                        err_reg <= 1'b1;
                        if (gnt_d_reg) d_rdata_reg <= 32'h0;
                        else           if_rdata_reg <= 32'h0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_we    = we_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mips150_mem_arbiter.sv
// Self-checking bench for mips150_mem_arbiter: directed scenarios plus randomized
// single-requester traffic checked against a transaction-level reference model.
module tb_mips150_mem_arbiter;
    localparam int WAIT_LIMIT   = 16;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_we;
    logic        if_ack, d_ack, d_misalign, err, mem_valid, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    always #5 clk = ~clk;

    mips150_mem_arbiter #(.WAIT_LIMIT(WAIT_LIMIT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_misalign(d_misalign), .err(err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last value each rdata output should be holding
    logic [31:0] last_if_rdata = 32'h0;
    logic [31:0] last_d_rdata  = 32'h0;

    // Observations of the most recent access
    int          o_lat, o_valid_lat, o_valid_cycles;
    logic [31:0] o_addr, o_wdata, o_if_rdata, o_d_rdata;
    logic [3:0]  o_we;
    logic        o_if_ack, o_d_ack, o_err, o_mis, o_stall_low, o_moved, o_stray;

    function automatic logic [3:0] model_mask(input logic [1:0] we, input logic [1:0] a);
        case (we)
            2'd1:    return 4'(1 << a);
            2'd2:    return (a >= 2'd2) ? 4'b1100 : 4'b0011;
            2'd3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_data(input logic [1:0] we, input logic [31:0] w);
        case (we)
            2'd1:    return {24'h0, w[7:0]} * 32'h0101_0101;
            2'd2:    return {16'h0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic model_mis(input logic [1:0] we, input logic [1:0] a);
        return (we == 2'd2 && a[0]) || (we == 2'd3 && a != 2'd0);
    endfunction

    task automatic drive_data(input logic [1:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        if_req = 1'b1; if_addr = addr;
    endtask

    task automatic finish_txn();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    // Plays the memory side until an ack appears (bounded); ready comes after `delay` extra valid cycles
    task automatic run_access(input int delay, input logic [31:0] rdata);
        o_lat = -1; o_valid_lat = -1; o_valid_cycles = 0;
        o_if_ack = 1'b0; o_d_ack = 1'b0; o_err = 1'b0; o_mis = 1'b0;
        o_stall_low = 1'b0; o_moved = 1'b0; o_stray = 1'b0;
        o_addr = 32'h0; o_we = 4'h0; o_wdata = 32'h0; o_if_rdata = 32'h0; o_d_rdata = 32'h0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                o_lat = cyc; o_if_ack = if_ack; o_d_ack = d_ack; o_err = err; o_mis = d_misalign;
                o_if_rdata = if_rdata; o_d_rdata = d_rdata;
                mem_ready = 1'b0;
                break;
            end
            if (!stall) o_stall_low = 1'b1;
            if (err || d_misalign) o_stray = 1'b1;
            if (mem_valid) begin
                if (o_valid_cycles == 0) begin
                    o_valid_lat = cyc; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wdata} !== {o_addr, o_we, o_wdata}) begin
                    o_moved = 1'b1;
                end
                o_valid_cycles++;
                mem_ready = (o_valid_cycles > delay);
                mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
        if (o_lat < 0) mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 2'b00; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if_ack, d_ack, d_misalign, err, mem_valid, mem_we, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b/%b mis=%b err=%b valid=%b we=%b ifr=%h dr=%h addr=%h wd=%h, expected all zero",
                     if_ack, d_ack, d_misalign, err, mem_valid, mem_we, if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b expected 0", stall); end
        if_req = 1'b1; #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %b expected 1", stall); end
        if_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset released");
    endtask

    task automatic test_fetch();
        drive_fetch(32'h0000_1004);
        run_access(0, 32'h2408_0005);
        n_checks++;
        if (o_addr !== 32'h0000_1004 || o_we !== 4'b0000) begin
            n_fail++; $display("FAIL fetch_addr: got addr=%h we=%b expected 00001004/0000", o_addr, o_we);
        end
        n_checks++;
        if (o_if_ack !== 1'b1 || o_d_ack !== 1'b0 || o_if_rdata !== 32'h2408_0005) begin
            n_fail++; $display("FAIL fetch_ack: got if_ack=%b d_ack=%b rdata=%h expected 1/0/24080005", o_if_ack, o_d_ack, o_if_rdata);
        end
        n_checks++;
        if (o_lat !== 2 || o_valid_lat !== 1) begin
            n_fail++; $display("FAIL fetch_latency: got ack@%0d valid@%0d expected 2/1", o_lat, o_valid_lat);
        end
        last_if_rdata = 32'h2408_0005;
        finish_txn();
        n_checks++;
        if (if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got if_ack=%b one cycle later expected 0", if_ack); end
        $display("txn fetch addr=00001004 rdata=%h", o_if_rdata);
    endtask

    task automatic test_stores();
        drive_data(2'b01, 32'h1000_0003, 32'h0000_00AB);
        run_access(0, 32'hDEAD_BEEF);
        n_checks++;
        if (o_we !== 4'b1000 || o_wdata !== 32'hABAB_ABAB || o_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL store_byte: got we=%b wd=%h addr=%h expected 1000/ABABABAB/10000000", o_we, o_wdata, o_addr);
        end
        n_checks++;
        if (o_d_ack !== 1'b1 || o_d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL store_byte_ack: got ack=%b rdata=%h expected 1/0", o_d_ack, o_d_rdata);
        end
        last_d_rdata = 32'h0;
        finish_txn();
        $display("txn store byte we=%b wdata=%h", o_we, o_wdata);
        drive_data(2'b10, 32'h2000_0002, 32'h0000_1234);
        run_access(1, 32'h1111_2222);
        n_checks++;
        if (o_we !== 4'b1100 || o_wdata !== 32'h1234_1234 || o_valid_cycles !== 2) begin
            n_fail++; $display("FAIL store_half: got we=%b wd=%h valid=%0d expected 1100/12341234/2", o_we, o_wdata, o_valid_cycles);
        end
        finish_txn();
        $display("txn store half we=%b wdata=%h", o_we, o_wdata);
    endtask

    task automatic test_misalign();
        drive_data(2'b11, 32'h3000_0002, 32'hCAFE_F00D);
        run_access(0, 32'h5555_5555);
        n_checks++;
        if (o_valid_cycles !== 0 || o_lat !== 1) begin
            n_fail++; $display("FAIL misalign_timing: got valid=%0d ack@%0d expected 0/1", o_valid_cycles, o_lat);
        end
        n_checks++;
        if (o_d_ack !== 1'b1 || o_mis !== 1'b1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL misalign_flags: got ack=%b mis=%b err=%b expected 1/1/0", o_d_ack, o_mis, o_err);
        end
        finish_txn();
        n_checks++;
        if (d_misalign !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got mis=%b ack=%b after RESP expected 0/0", d_misalign, d_ack);
        end
        $display("txn misaligned store word addr=30000002");
    endtask

    task automatic test_ready_ignored();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_valid !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
                n_fail++; $display("FAIL ready_ignored: got valid=%b ack=%b/%b expected 0/0/0", mem_valid, if_ack, d_ack);
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        is_d, mis;
            logic [1:0]  we;
            logic [31:0] addr, wdata, rd, exp_rd;
            int          delay, exp_lat;
            logic [3:0]  exp_we;
            is_d  = $urandom_range(0, 2) != 0;
            we    = 2'($urandom_range(0, 3));
            addr  = $urandom;
            wdata = $urandom;
            rd    = $urandom;
            delay = $urandom_range(0, 3);
            d_we = we; d_addr = addr; d_wdata = wdata;
            if (is_d) drive_data(we, addr, wdata); else drive_fetch(addr);
            mis     = is_d && model_mis(we, addr[1:0]);
            exp_lat = mis ? 1 : delay + 2;
            exp_we  = is_d ? model_mask(we, addr[1:0]) : 4'b0000;
            exp_rd  = (is_d && we != 2'b00) ? 32'h0 : rd;
            run_access(delay, rd);
            n_checks++;
            if (o_lat !== exp_lat || o_valid_cycles !== (mis ? 0 : delay + 1)) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got ack@%0d valid=%0d expected ack@%0d valid=%0d",
                                   t, o_lat, o_valid_cycles, exp_lat, mis ? 0 : delay + 1);
            end
            n_checks++;
            if (o_d_ack !== is_d || o_if_ack !== !is_d || o_mis !== mis || o_err !== 1'b0) begin
                n_fail++; $display("FAIL rand_ack[%0d]: got d=%b if=%b mis=%b err=%b expected d=%b mis=%b err=0",
                                   t, o_d_ack, o_if_ack, o_mis, o_err, is_d, mis);
            end
            if (!mis) begin
                n_checks++;
                if (o_addr !== {addr[31:2], 2'b00} || o_we !== exp_we ||
                    (is_d && we != 2'b00 && o_wdata !== model_data(we, wdata))) begin
                    n_fail++; $display("FAIL rand_request[%0d]: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                                       t, o_addr, o_we, o_wdata, {addr[31:2], 2'b00}, exp_we, model_data(we, wdata));
                end
            end
            if (is_d) last_d_rdata = exp_rd; else last_if_rdata = exp_rd;
            n_checks++;
            if (o_d_rdata !== last_d_rdata || o_if_rdata !== last_if_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got d=%h if=%h expected d=%h if=%h",
                                   t, o_d_rdata, o_if_rdata, last_d_rdata, last_if_rdata);
            end
            n_checks++;
            if (o_stall_low !== 1'b0 || o_moved !== 1'b0 || o_stray !== 1'b0) begin
                n_fail++; $display("FAIL rand_hold[%0d]: got stall_low=%b moved=%b stray=%b expected 0/0/0",
                                   t, o_stall_low, o_moved, o_stray);
            end
            $display("txn rand %0d %s we=%b addr=%h delay=%0d mis=%b", t, is_d ? "data " : "fetch", we, addr, delay, mis);
            finish_txn();
        end
    endtask

    task automatic test_contention();
        int cnt;
        logic exp_d;
        logic [31:0] rd;
        drive_fetch(32'h0000_0100);
        run_access(0, 32'h0000_0BAD);
        last_if_rdata = 32'h0000_0BAD;
        finish_txn();
        cnt = 0;
        drive_fetch(32'h0000_0200);
        drive_data(2'b00, 32'h0000_0300, 32'h0);
        for (int g = 0; g < 10; g++) begin
            exp_d = (cnt != STARVE_LIMIT);
            cnt   = exp_d ? cnt + 1 : 0;
            rd    = $urandom;
            run_access(0, rd);
            if (exp_d) last_d_rdata = rd; else last_if_rdata = rd;
            n_checks++;
            if (o_d_ack !== exp_d || o_if_ack !== !exp_d) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got d_ack=%b if_ack=%b expected d_ack=%b", g, o_d_ack, o_if_ack, exp_d);
            end
            n_checks++;
            if (stall !== 1'b1 || o_stall_low !== 1'b0) begin
                n_fail++; $display("FAIL contention_stall[%0d]: got stall=%b low_seen=%b expected 1/0", g, stall, o_stall_low);
            end
            $display("txn contention %0d granted %s", g, o_d_ack ? "data" : "fetch");
        end
        finish_txn();
    endtask

    task automatic test_timeout();
        drive_data(2'b00, 32'h4000_0010, 32'h0);
        run_access(1000, 32'h7777_7777);
        n_checks++;
        if (o_valid_cycles !== WAIT_LIMIT || o_lat !== WAIT_LIMIT + 1) begin
            n_fail++; $display("FAIL timeout_len: got valid=%0d ack@%0d expected %0d/%0d", o_valid_cycles, o_lat, WAIT_LIMIT, WAIT_LIMIT + 1);
        end
        n_checks++;
        if (o_d_ack !== 1'b1 || o_err !== 1'b1 || o_d_rdata !== 32'h0 || o_stray !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: got ack=%b err=%b rdata=%h stray=%b expected 1/1/0/0", o_d_ack, o_err, o_d_rdata, o_stray);
        end
        last_d_rdata = 32'h0;
        finish_txn();
        $display("txn timeout load valid_cycles=%0d", o_valid_cycles);
        drive_data(2'b00, 32'h4000_0014, 32'h0);
        run_access(1, 32'h1357_9BDF);
        n_checks++;
        if (o_err !== 1'b0 || o_d_rdata !== 32'h1357_9BDF || o_lat !== 3) begin
            n_fail++; $display("FAIL timeout_recover: got err=%b rdata=%h ack@%0d expected 0/13579bdf/3", o_err, o_d_rdata, o_lat);
        end
        last_d_rdata = 32'h1357_9BDF;
        finish_txn();
        $display("txn load after timeout rdata=%h", o_d_rdata);
    endtask

    task automatic test_reset_busy();
        logic saw_ack;
        drive_data(2'b00, 32'h5000_0020, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL rstbusy_valid: got %b before reset expected 1", mem_valid); end
        rst_n = 1'b0; #1;
        n_checks++;
        if ({if_ack, d_ack, d_misalign, err, mem_valid, mem_we, if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL rstbusy_async: got valid=%b ack=%b/%b addr=%h dr=%h ifr=%h expected all zero",
                               mem_valid, if_ack, d_ack, mem_addr, d_rdata, if_rdata);
        end
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rstbusy_stall: got %b with d_req high expected 1", stall); end
        saw_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (if_ack || d_ack) saw_ack = 1'b1;
        end
        rst_n = 1'b1;
        last_d_rdata = 32'h0; last_if_rdata = 32'h0;
        run_access(0, 32'h0BAD_CAFE);
        n_checks++;
        if (saw_ack !== 1'b0 || o_lat !== 2 || o_d_ack !== 1'b1 || o_d_rdata !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL rstbusy_regrant: got stray_ack=%b ack@%0d d_ack=%b rdata=%h expected 0/2/1/0badcafe",
                               saw_ack, o_lat, o_d_ack, o_d_rdata);
        end
        last_d_rdata = 32'h0BAD_CAFE;
        finish_txn();
        $display("txn reset during busy then regrant rdata=%h", o_d_rdata);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a, rd;
            a  = 32'h6000_0000 + 32'(k * 4);
            rd = $urandom;
            drive_data(2'b00, a, 32'h0);
            run_access(0, rd);
            n_checks++;
            if (o_valid_lat !== 1 || o_lat !== 2 || o_addr !== a || o_d_rdata !== rd) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got valid@%0d ack@%0d addr=%h rdata=%h expected 1/2/%h/%h",
                                   k, o_valid_lat, o_lat, o_addr, o_d_rdata, a, rd);
            end
            last_d_rdata = rd;
            finish_txn();
            $display("txn back_to_back %0d addr=%h", k, a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_stores();
        test_misalign();
        test_ready_ignored();
        test_random();
        test_contention();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
